// File: rtl/mem_sched_pkg.sv
// Shared types and defaults for the scheduled register-array memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_BUMP = 2'd2
    } state_t;

    localparam int DW_DEF    = 4;
    localparam int DEPTH_DEF = 8;

    // Address width for a given depth; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the favoured requester on contention.
// Latency: grant is combinational from valid/advance; pointer updates at the grant edge.
// Backpressure: no grant at all while advance is low; pointer only moves on contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;  // 0 favours requester 0, 1 favours requester 1

    // Grant the lone requester, or the favoured one when both ask.
    always_comb begin
        grant = 2'b00;
        if (advance) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // After a contended grant, hand priority to the requester that lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (advance && (valid == 2'b11)) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/mem_sched_ctrl.sv
// Register array with arbitrated write port and INIT/BUMP bulk walks over every entry.
// Latency: writes visible one cycle after commit; a walk takes DEPTH cycles, done one cycle later.
// Backpressure: requesters see ready=0 while a walk runs or a start is being accepted.
module mem_sched_ctrl
    import mem_sched_pkg::*;
#(
    parameter int  DW    = DW_DEF,
    parameter int  DEPTH = DEPTH_DEF,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init_start,
    input  logic          bump_start,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done
);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          done_q, done_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_dat;
    logic          start_acc;
    logic          advance;
    logic [1:0]    grant;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // A start accepted in IDLE takes the cycle; requesters only compete otherwise.
    assign start_acc = (state == ST_IDLE) && (init_start || bump_start);
    assign advance   = reset_n && (state == ST_IDLE) && !start_acc;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   ({req1_valid, req0_valid}),
        .advance (advance),
        .grant   (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign busy       = (state != ST_IDLE);
    assign done       = done_q;
    assign rd_data    = in_range(rd_addr) ? mem[rd_addr] : '0;

    // Sequencer: pick the next state and the single write this cycle performs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = cnt;
        wr_dat    = '0;
        case (state)
            ST_IDLE: begin
                if (init_start) begin
                    state_nxt = ST_INIT;
                end else if (bump_start) begin
                    state_nxt = ST_BUMP;
                end else if (grant[0]) begin
                    // Out-of-range writes are consumed without touching the array.
                    wr_en   = in_range(req0_addr);
                    wr_addr = req0_addr;
                    wr_dat  = req0_data;
                end else if (grant[1]) begin
                    wr_en   = in_range(req1_addr);
                    wr_addr = req1_addr;
                    wr_dat  = req1_data;
                end
            end
            ST_INIT, ST_BUMP: begin
                wr_en  = 1'b1;
                wr_dat = (state == ST_INIT) ? DW'(cnt) : mem[cnt] + DW'(1);
                if (cnt == AW'(DEPTH - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Sequencer state, walk counter and the registered done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    // Storage array; reset clears every entry so an aborted walk leaves no residue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

endmodule

// File: tb/tb_mem_sched_ctrl.sv
module tb_mem_sched_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       init_start = 1'b0;
    logic       bump_start = 1'b0;
    logic       req0_valid = 1'b0;
    logic [2:0] req0_addr = '0;
    logic [3:0] req0_data = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [2:0] req1_addr = '0;
    logic [3:0] req1_data = '0;
    logic       req1_ready;
    logic [2:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b1;

    always #5 clk = ~clk;

    mem_sched_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .init_start (init_start),
        .bump_start (bump_start),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- behavioural model ----------------
    int m_mem [DEPTH] = '{default: 0};
    int m_left = 0;       // walk cycles still to run; 0 means idle
    bit m_bump = 1'b0;    // current walk is BUMP
    bit m_done = 1'b0;
    bit m_fav1 = 1'b0;    // requester 1 wins the next contention

    function automatic logic [1:0] exp_grant();
        if (!reset_n || m_left > 0 || init_start || bump_start) return 2'b00;
        if (req0_valid && req1_valid) return m_fav1 ? 2'b10 : 2'b01;
        return {req1_valid, req0_valid};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) m_mem[k] = 0;
            m_left = 0;
            m_bump = 1'b0;
            m_done = 1'b0;
            m_fav1 = 1'b0;
        end else begin
            logic [1:0] g;
            g = exp_grant();
            m_done = 1'b0;
            if (m_left > 0) begin
                int idx;
                idx = DEPTH - m_left;
                m_mem[idx] = m_bump ? (m_mem[idx] + 1) % 16 : idx % 16;
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (init_start) begin
                m_left = DEPTH;
                m_bump = 1'b0;
            end else if (bump_start) begin
                m_left = DEPTH;
                m_bump = 1'b1;
            end else begin
                if (g[0] && int'(req0_addr) < DEPTH) m_mem[req0_addr] = int'(req0_data);
                if (g[1] && int'(req1_addr) < DEPTH) m_mem[req1_addr] = int'(req1_data);
                if (req0_valid && req1_valid) m_fav1 = !m_fav1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            logic [1:0] g;
            g = exp_grant();
            chk("busy", 32'(busy), 32'(reset_n && m_left > 0));
            chk("done", 32'(done), 32'(reset_n && m_done));
            chk("req0_ready", 32'(req0_ready), 32'(g[0]));
            chk("req1_ready", 32'(req1_ready), 32'(g[1]));
            chk("rd_data", 32'(rd_data), 32'(m_mem[rd_addr]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input bit is_init, output int busy_n, output logic done_seen);
        if (is_init) init_start = 1'b1;
        else         bump_start = 1'b1;
        tick();
        init_start = 1'b0;
        bump_start = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            busy_n++;
            tick();
        end
        done_seen = done;
    endtask

    initial begin
        int bn;
        logic ds;
        int low_n;

        // 1. reset state
        repeat (3) tick();
        chk("reset_ready0", 32'(req0_ready), 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 3'(a);
            #1;
            chk("reset_rd", 32'(rd_data), 32'd0);
        end
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        tick();

        // 2. INIT
        run_seq(1'b1, bn, ds);
        chk("init_busy_cycles", 32'(bn), 32'd8);
        chk("init_done", 32'(ds), 32'd1);
        tick();
        chk("init_done_pulse_end", 32'(done), 32'd0);
        rd_addr = 3'd5; #1;
        chk("init_rd5", 32'(rd_data), 32'd5);
        rd_addr = 3'd7; #1;
        chk("init_rd7", 32'(rd_data), 32'd7);

        // 3. nine BUMPs, entry 7 wraps through 16
        for (int b = 0; b < 9; b++) begin
            run_seq(1'b0, bn, ds);
            chk("bump_busy_cycles", 32'(bn), 32'd8);
            chk("bump_done", 32'(ds), 32'd1);
            tick();
        end
        rd_addr = 3'd7; #1;
        chk("bump_rd7_wrap", 32'(rd_data), 32'd0);
        rd_addr = 3'd0; #1;
        chk("bump_rd0", 32'(rd_data), 32'd9);

        // 4. contention on address 2
        req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 4'hA;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 4'hB;
        rd_addr = 3'd2; #1;
        chk("rr_g0_ready0", 32'(req0_ready), 32'd1);
        chk("rr_g0_ready1", 32'(req1_ready), 32'd0);
        chk("rr_old_value", 32'(rd_data), 32'd11);
        tick();
        chk("rr_mem_a", 32'(rd_data), 32'hA);
        chk("rr_g1_ready1", 32'(req1_ready), 32'd1);
        chk("rr_g1_ready0", 32'(req0_ready), 32'd0);
        tick();
        chk("rr_mem_b", 32'(rd_data), 32'hB);
        chk("rr_g2_ready0", 32'(req0_ready), 32'd1);
        tick();
        chk("rr_mem_a2", 32'(rd_data), 32'hA);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // 5. requester held off by INIT
        req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 4'h5;
        init_start = 1'b1; #1;
        chk("start_no_grant", 32'(req0_ready), 32'd0);
        tick();
        init_start = 1'b0;
        low_n = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!busy) break;
            if (!req0_ready) low_n++;
            tick();
        end
        chk("held_ready_low", 32'(low_n), 32'd8);
        chk("held_done", 32'(done), 32'd1);
        chk("held_granted", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        rd_addr = 3'd3; #1;
        chk("held_write", 32'(rd_data), 32'd5);
        tick();

        // 6. reset during BUMP
        bump_start = 1'b1;
        tick();
        bump_start = 1'b0;
        tick();
        tick();
        req0_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready0", 32'(req0_ready), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 3'(a);
            #1;
            chk("abort_rd", 32'(rd_data), 32'd0);
        end
        tick();
        req0_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
